// File: rtl/hdmi_period_scheduler.sv
// HDMI TMDS period sequencer for the horizontal blanking interval, with data-island packet arbitration.
// Define HDMI_SCHED_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module hdmi_period_scheduler #(
    parameter int NUM_REQ     = 2,
    parameter int BLANK_LEN   = 384,
    parameter int CTRL_LEAD   = 4,
    parameter int MAX_PACKETS = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               line_start,
    input  logic               vblank,
    input  logic [NUM_REQ-1:0] pkt_req,
    output logic [2:0]         period,
    output logic [3:0]         ctl,
    output logic [NUM_REQ-1:0] pkt_grant,
    output logic [4:0]         pkt_word,
    output logic               pkt_start,
    output logic               sched_err
);

    localparam int BCW = 12;
    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [BCW-1:0] BC_MAX = '1;

    localparam logic [2:0] P_CTRL    = 3'd0;
    localparam logic [2:0] P_DI_PRE  = 3'd1;
    localparam logic [2:0] P_DI_GB   = 3'd2;
    localparam logic [2:0] P_DI_DATA = 3'd3;
    localparam logic [2:0] P_VID_PRE = 3'd4;
    localparam logic [2:0] P_VID_GB  = 3'd5;
    localparam logic [2:0] P_ACTIVE  = 3'd6;

    typedef enum logic [3:0] {
        S_IDLE, S_CTRL_A, S_DI_PRE, S_DI_GB_LEAD, S_DI_DATA,
        S_DI_GB_TRAIL, S_CTRL_B, S_VID_PRE, S_VID_GB, S_ACTIVE
    } state_t;

    state_t             state_q, state_d;
    logic [BCW-1:0]     bc_q, bc_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [4:0]         npk_q, npk_d;
    logic               vb_q, vb_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               err_q, err_d;
    logic [2:0]         period_q, period_d;
    logic [3:0]         ctl_q, ctl_d;
    logic [4:0]         word_q, word_d;
    logic               start_q, start_d;

    logic               fit_first, fit_more, in_sched;
    logic [IW-1:0]      arb_base;
    logic [NUM_REQ-1:0] arb_gnt;
    logic               arb_hit;

`ifdef HDMI_SCHED_RR_EN
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      gidx_next;
    logic [IW-1:0]      arb_idx;

    // During a packet the next search starts just past the source being served.
    always_comb begin
        gidx_next = (int'(gidx_q) == NUM_REQ - 1) ? '0 : gidx_q + IW'(1);
        arb_base  = (state_q == S_DI_DATA) ? gidx_next : rr_ptr_q;
    end
`else
    always_comb arb_base = '0;
`endif

    always_comb begin
        arb_gnt = '0;
        arb_hit = 1'b0;
`ifdef HDMI_SCHED_RR_EN
        arb_idx = '0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!arb_hit && pkt_req[(int'(arb_base) + k) % NUM_REQ]) begin
                arb_hit = 1'b1;
                arb_gnt[(int'(arb_base) + k) % NUM_REQ] = 1'b1;
`ifdef HDMI_SCHED_RR_EN
                arb_idx = IW'((int'(arb_base) + k) % NUM_REQ);
`endif
            end
        end
    end

    // Packet 32 + trailing guard 2 + margin 4 + video preamble/guard 10; first island also pays its own preamble/guard.
    always_comb begin
        fit_more  = (int'(bc_q) + 48) <= BLANK_LEN;
        fit_first = (int'(bc_q) + 58) <= BLANK_LEN;
        in_sched  = (state_q == S_DI_PRE) || (state_q == S_DI_GB_LEAD) ||
                    (state_q == S_DI_DATA) || (state_q == S_DI_GB_TRAIL) ||
                    (state_q == S_VID_PRE) || (state_q == S_VID_GB);
    end

    always_comb begin
        state_d = state_q;
        bc_d    = (bc_q == BC_MAX) ? bc_q : bc_q + BCW'(1);
        cnt_d   = cnt_q + 5'd1;
        npk_d   = npk_q;
        vb_d    = vb_q;
        grant_d = grant_q;
        err_d   = err_q;
`ifdef HDMI_SCHED_RR_EN
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
`endif
        case (state_q)
            S_CTRL_A: begin
                if (int'(bc_q) >= CTRL_LEAD) begin
                    cnt_d   = '0;
                    state_d = (|pkt_req && fit_first) ? S_DI_PRE : S_CTRL_B;
                end
            end
            S_DI_PRE: begin
                if (cnt_q == 5'd7) begin
                    cnt_d   = '0;
                    state_d = S_DI_GB_LEAD;
                end
            end
            S_DI_GB_LEAD: begin
                if (cnt_q == 5'd1) begin
                    cnt_d   = '0;
                    state_d = S_DI_DATA;
                    grant_d = arb_gnt;
                    npk_d   = 5'd1;
`ifdef HDMI_SCHED_RR_EN
                    gidx_d  = arb_idx;
`endif
                end
            end
            S_DI_DATA: begin
                if (cnt_q == 5'd31) begin
`ifdef HDMI_SCHED_RR_EN
                    if (|grant_q) rr_ptr_d = gidx_next;
`endif
                    if (arb_hit && (int'(npk_q) < MAX_PACKETS) && fit_more) begin
                        grant_d = arb_gnt;
                        npk_d   = npk_q + 5'd1;
`ifdef HDMI_SCHED_RR_EN
                        gidx_d  = arb_idx;
`endif
                    end else begin
                        grant_d = '0;
                        cnt_d   = '0;
                        state_d = S_DI_GB_TRAIL;
                    end
                end
            end
            S_DI_GB_TRAIL: begin
                if (cnt_q == 5'd1) state_d = S_CTRL_B;
            end
            S_CTRL_B: begin
                if (!vb_q && (int'(bc_q) >= BLANK_LEN - 10)) begin
                    cnt_d   = '0;
                    state_d = S_VID_PRE;
                end
            end
            S_VID_PRE: begin
                if (cnt_q == 5'd7) begin
                    cnt_d   = '0;
                    state_d = S_VID_GB;
                end
            end
            S_VID_GB: begin
                if (cnt_q == 5'd1) state_d = S_ACTIVE;
            end
            default: ;
        endcase

        // A new line always wins; landing inside an island or video lead-in is an overrun.
        if (line_start) begin
            if (in_sched) err_d = 1'b1;
            state_d = S_CTRL_A;
            bc_d    = '0;
            cnt_d   = '0;
            npk_d   = '0;
            vb_d    = vblank;
            grant_d = '0;
`ifdef HDMI_SCHED_RR_EN
            rr_ptr_d = rr_ptr_q;
`endif
        end

        period_d = P_CTRL;
        ctl_d    = 4'b0000;
        case (state_d)
            S_DI_PRE:                    begin period_d = P_DI_PRE;  ctl_d = 4'b0101; end
            S_DI_GB_LEAD, S_DI_GB_TRAIL: period_d = P_DI_GB;
            S_DI_DATA:                   period_d = P_DI_DATA;
            S_VID_PRE:                   begin period_d = P_VID_PRE; ctl_d = 4'b0001; end
            S_VID_GB:                    period_d = P_VID_GB;
            S_ACTIVE:                    period_d = P_ACTIVE;
            default:                     period_d = P_CTRL;
        endcase
        word_d  = (state_d == S_DI_DATA) ? cnt_d : 5'd0;
        start_d = (state_d == S_DI_DATA) && (cnt_d == 5'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bc_q     <= '0;
            cnt_q    <= '0;
            npk_q    <= '0;
            vb_q     <= 1'b0;
            grant_q  <= '0;
            err_q    <= 1'b0;
            period_q <= P_CTRL;
            ctl_q    <= 4'b0000;
            word_q   <= 5'd0;
            start_q  <= 1'b0;
`ifdef HDMI_SCHED_RR_EN
            rr_ptr_q <= '0;
            gidx_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            bc_q     <= bc_d;
            cnt_q    <= cnt_d;
            npk_q    <= npk_d;
            vb_q     <= vb_d;
            grant_q  <= grant_d;
            err_q    <= err_d;
            period_q <= period_d;
            ctl_q    <= ctl_d;
            word_q   <= word_d;
            start_q  <= start_d;
`ifdef HDMI_SCHED_RR_EN
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
`endif
        end
    end

    assign period    = period_q;
    assign ctl       = ctl_q;
    assign pkt_grant = grant_q;
    assign pkt_word  = word_q;
    assign pkt_start = start_q;
    assign sched_err = err_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Bench for hdmi_period_scheduler: three instances (MAX_PACKETS 2, 1, 18) share stimulus and are
// compared cycle by cycle against a line-schedule model built from cycle arithmetic.
module tb_hdmi_period_scheduler;

    localparam int B = 384;
    localparam int L = 4;

    logic clk = 1'b0;
    logic reset, line_start, vblank;
    logic [1:0] pkt_req;

    logic [2:0] per_o   [3];
    logic [3:0] ctl_o   [3];
    logic [1:0] gnt_o   [3];
    logic [4:0] word_o  [3];
    logic       start_o [3];
    logic       err_o   [3];

    int checks = 0;
    int errors = 0;

    int   max_p [3] = '{2, 1, 18};
    int   npk [3];
    logic [1:0] gl [3][18];
    int   ptr_after [3][18];
    int   ptr [3];
    bit   err_m [3];
    bit   vbl;
    bit   have_prev;
    int   last_len;

    always #5 clk = ~clk;

    hdmi_period_scheduler #(.MAX_PACKETS(2)) u_a (
        .clk(clk), .reset(reset), .line_start(line_start), .vblank(vblank), .pkt_req(pkt_req),
        .period(per_o[0]), .ctl(ctl_o[0]), .pkt_grant(gnt_o[0]), .pkt_word(word_o[0]),
        .pkt_start(start_o[0]), .sched_err(err_o[0]));

    hdmi_period_scheduler #(.MAX_PACKETS(1)) u_b (
        .clk(clk), .reset(reset), .line_start(line_start), .vblank(vblank), .pkt_req(pkt_req),
        .period(per_o[1]), .ctl(ctl_o[1]), .pkt_grant(gnt_o[1]), .pkt_word(word_o[1]),
        .pkt_start(start_o[1]), .sched_err(err_o[1]));

    hdmi_period_scheduler #(.MAX_PACKETS(18)) u_c (
        .clk(clk), .reset(reset), .line_start(line_start), .vblank(vblank), .pkt_req(pkt_req),
        .period(per_o[2]), .ctl(ctl_o[2]), .pkt_grant(gnt_o[2]), .pkt_word(word_o[2]),
        .pkt_start(start_o[2]), .sched_err(err_o[2]));

    task automatic chk(input string tag, input int i, input int k, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cycle=%0d observed=%0h expected=%0h", tag, i, k, obs, exp);
        end
    endtask

    function automatic int pick(input logic [1:0] req, input int p);
`ifdef HDMI_SCHED_RR_EN
        for (int s = 0; s < 2; s++) if (req[(p + s) % 2]) return (p + s) % 2;
`else
        for (int s = 0; s < 2; s++) if (req[s]) return s;
`endif
        return 0;
    endfunction

    // Expected outputs k clocks after the line_start edge, from the line's packet schedule.
    task automatic exp_at(input int i, input int k, output logic [2:0] ep, output logic [3:0] ec,
                          output logic [1:0] eg, output logic [4:0] ew, output logic es);
        int d0, dend;
        d0 = L + 11;
        dend = d0 + 32 * npk[i];
        ep = 3'd0; ec = 4'd0; eg = 2'd0; ew = 5'd0; es = 1'b0;
        if (npk[i] > 0 && k >= L + 1 && k <= L + 8) begin
            ep = 3'd1; ec = 4'b0101;
        end else if (npk[i] > 0 && ((k >= L + 9 && k <= L + 10) || (k >= dend && k <= dend + 1))) begin
            ep = 3'd2;
        end else if (npk[i] > 0 && k >= d0 && k < dend) begin
            ep = 3'd3;
            eg = gl[i][(k - d0) / 32];
            ew = 5'((k - d0) % 32);
            es = (ew == 5'd0);
        end else if (!vbl && k >= B - 9 && k <= B - 2) begin
            ep = 3'd4; ec = 4'b0001;
        end else if (!vbl && k >= B - 1 && k <= B) begin
            ep = 3'd5;
        end else if (!vbl && k > B) begin
            ep = 3'd6;
        end
    endtask

    task automatic model_start(input bit vb, input logic [1:0] req);
        logic [2:0] ep; logic [3:0] ec; logic [1:0] eg; logic [4:0] ew; logic es;
        int n, p, c, idx;
        for (int i = 0; i < 3; i++) begin
            if (have_prev) begin
                c = 0;
                for (int j = 0; j < npk[i]; j++) if (L + 43 + 32 * j <= last_len - 1) c++;
                if (c > 0) ptr[i] = ptr_after[i][c - 1];
                exp_at(i, last_len - 1, ep, ec, eg, ew, es);
                if (ep >= 3'd1 && ep <= 3'd5) err_m[i] = 1'b1;
            end
            n = 0;
            if (req != 2'b00 && L + 58 <= B) begin
                n = 1;
                while (n < max_p[i] && (L + 42 + 32 * (n - 1)) + 48 <= B) n++;
            end
            npk[i] = n;
            p = ptr[i];
            for (int j = 0; j < n; j++) begin
                idx = pick(req, p);
                gl[i][j] = 2'b01 << idx;
                p = (idx + 1) % 2;
                ptr_after[i][j] = p;
            end
        end
        vbl = vb;
        have_prev = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            ptr[i] = 0; err_m[i] = 1'b0; npk[i] = 0;
        end
        have_prev = 1'b0;
        last_len = 0;
    endtask

    task automatic check_all(input int k);
        logic [2:0] ep; logic [3:0] ec; logic [1:0] eg; logic [4:0] ew; logic es;
        for (int i = 0; i < 3; i++) begin
            exp_at(i, k, ep, ec, eg, ew, es);
            chk("period", i, k, 8'(per_o[i]), 8'(ep));
            chk("ctl", i, k, 8'(ctl_o[i]), 8'(ec));
            chk("grant", i, k, 8'(gnt_o[i]), 8'(eg));
            chk("word", i, k, 8'(word_o[i]), 8'(ew));
            chk("start", i, k, 8'(start_o[i]), 8'(es));
            chk("sched_err", i, k, 8'(err_o[i]), 8'(err_m[i]));
        end
    endtask

    task automatic check_idle(input int tag_k);
        for (int i = 0; i < 3; i++) begin
            chk("rst_period", i, tag_k, 8'(per_o[i]), 8'd0);
            chk("rst_ctl", i, tag_k, 8'(ctl_o[i]), 8'd0);
            chk("rst_grant", i, tag_k, 8'(gnt_o[i]), 8'd0);
            chk("rst_word", i, tag_k, 8'(word_o[i]), 8'd0);
            chk("rst_start", i, tag_k, 8'(start_o[i]), 8'd0);
            chk("rst_err", i, tag_k, 8'(err_o[i]), 8'd0);
        end
    endtask

    task automatic run_line(input int len, input bit vb, input logic [1:0] req);
        line_start = 1'b1;
        vblank = vb;
        pkt_req = req;
        model_start(vb, req);
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            line_start = 1'b0;
            check_all(k);
        end
        last_len = len;
    endtask

    initial begin
        bit rvb;
        logic [1:0] rreq;
        int rlen;
        reset = 1'b1;
        line_start = 1'b0;
        vblank = 1'b0;
        pkt_req = 2'b00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_idle(-1);
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_idle(-1);
        end

        run_line(400, 1'b0, 2'b01);
        run_line(400, 1'b0, 2'b11);
        run_line(400, 1'b0, 2'b11);
        run_line(400, 1'b1, 2'b00);
        run_line(20, 1'b0, 2'b01);
        run_line(400, 1'b0, 2'b01);

        run_line(30, 1'b0, 2'b11);
        #2 reset = 1'b1;
        #1 check_idle(-2);
        #4 reset = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            check_idle(-3);
        end

        for (int n = 0; n < 9; n++) begin
            rreq = 2'($urandom_range(0, 3));
            rvb  = 1'($urandom_range(0, 1));
            rlen = (n % 3 == 2) ? int'($urandom_range(6, 90)) : int'($urandom_range(390, 410));
            run_line(rlen, rvb, rreq);
        end
        run_line(400, 1'b0, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
